jk_cmd_debouncer: RTL and testbench
===================================

# jk_cmd_debouncer

Upstream command stage for the JK flip-flop. It turns two raw mechanical push-buttons, SET and CLR, into clean single-cycle J and K pulses that drive the flip-flop's J/K inputs in the same Ck domain. Each button is synchronised, debounced with a consecutive-sample counter, and edge-detected, so one physical press yields exactly one pulse.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive identical synchronised samples required to accept a level change; legal range 2..65535.
- CNT_W, 16: counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- Ck  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Ck.
- BtnSet  input  1  raw asynchronous SET button (1 = pressed).
- BtnClr  input  1  raw asynchronous CLR button (1 = pressed).
- J  output  1  one-cycle pulse on each accepted SET press; feeds the flip-flop's J.
- K  output  1  one-cycle pulse on each accepted CLR press; feeds the flip-flop's K.
- Level  output  2  debounced button levels: bit 1 = SET, bit 0 = CLR.

## Operation
- Each button runs through an identical, independent channel: a 2-FF synchroniser (s1, s2), then a 4-state FSM with counter cnt.
- FSM states:
  - IDLE (level 0): s2=1 -> CHECK_HIGH, cnt=1; otherwise stay, cnt=0.
  - CHECK_HIGH: s2=0 -> IDLE, cnt=0 (glitch rejected); s2=1 and cnt==DEBOUNCE_CYCLES-1 -> HIGH, pulse=1; otherwise cnt+1.
  - HIGH (level 1): s2=0 -> CHECK_LOW, cnt=1; otherwise stay.
  - CHECK_LOW: s2=1 -> HIGH, cnt=0; s2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, no pulse; otherwise cnt+1.
- A press is accepted only after DEBOUNCE_CYCLES consecutive high samples of s2. A release is accepted the same way with low samples.
- Release never generates a pulse.
- J/K are registered pulses. Each is high exactly one cycle, in the cycle after the CHECK_HIGH -> HIGH transition edge.
- Level bit = 1 in HIGH and CHECK_LOW, 0 in IDLE and CHECK_HIGH (registered).
- Simultaneous SET and CLR acceptance: J and K pulse in the same cycle. This is intentional and gives the JK toggle command; no arbitration.
- cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Reset:
  - clears s1, s2, cnt, J, K and Level to 0; FSM goes to IDLE.
  - Reset has priority over all other events in the same cycle.
  - A button held through reset is re-debounced from IDLE after Reset deasserts and produces one J/K pulse. Intended: power-on with a held button issues one command.
- Reset mid-debounce discards the partial count. No pulse is emitted for that press unless it is fully re-qualified.

## Timing
- Reset values: J=0, K=0, Level=2'b00.
- Press latency: raw input high and stable before edge 0 -> s2=1 after edge 1 -> CHECK_HIGH after edge 2 -> pulse high after edge DEBOUNCE_CYCLES+1, low after edge DEBOUNCE_CYCLES+2.
- Level rises in the same cycle as the pulse.
- Release latency: Level falls after edge DEBOUNCE_CYCLES+1, counted from the first low raw sample before edge 0.
- Minimum press-to-press spacing is 2*DEBOUNCE_CYCLES cycles. Shorter activity is filtered.
- No combinational path from any input to any output.

## Structure
- Shared header jk_defs.vh holds the state encodings (IDLE=2'd0, CHECK_HIGH=2'd1, HIGH=2'd2, CHECK_LOW=2'd3) and the default DEBOUNCE_CYCLES.
- One sub-module, btn_debounce (synchroniser + FSM + counter, outputs pulse and level), instantiated twice in jk_cmd_debouncer.

## Test plan
Benches run with DEBOUNCE_CYCLES=4.
- Clean press: BtnSet 0->1 before edge 0, held 20 cycles -> J high only in the cycle after edge 5; K stays 0; Level[1]=1 from that cycle.
- Bounce rejection: BtnClr toggles 1,0,1,0 every cycle for 8 cycles, then 0 -> K never asserts; Level[0] stays 0.
- Bouncy press then stable: BtnSet pattern 1,0,1, then steady 1 -> exactly one J pulse, 5 cycles after the last 0->1 transition; release after 10 cycles produces no pulse and Level[1] falls 5 cycles later.
- Simultaneous press: BtnSet and BtnClr rise together before edge 0 -> J=K=1 in the same single cycle after edge 5; Level=2'b11.
- Reset mid-operation: BtnSet held, Reset=1 for one cycle at edge 3 -> no pulse at edge 5; outputs all 0 during reset; J pulses once 5 cycles after Reset deasserts (button still held).
- Held button: BtnSet high for 100 cycles -> exactly one J pulse total.

Source files
------------

// File: rtl/jk_cmd_debouncer_pkg.sv
// rtl/jk_cmd_debouncer_pkg.sv - shared state encodings and defaults for the JK command debouncer
//
// Purpose: per-button debounce FSM state type and the default qualification length.
// Ports:   none (package).

package jk_cmd_debouncer_pkg;

  // Debounce channel states. Level is 1 in HIGH and CHECK_LOW.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CHECK_HIGH = 2'd1,
    HIGH       = 2'd2,
    CHECK_LOW  = 2'd3
  } db_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/jk_cmd_debouncer_if.sv
// rtl/jk_cmd_debouncer_if.sv - button inputs and J/K command outputs of the debouncer
//
// Purpose: groups the raw buttons and the cleaned J/K/Level outputs.
// Signals: BtnSet, BtnClr (raw buttons, 1 = pressed)
//          J, K (single-cycle command pulses), Level[1:0] (debounced SET/CLR levels)
// Modports: master drives the buttons and observes the commands;
//           slave is the debouncer itself.

interface jk_cmd_debouncer_if;

  logic       BtnSet;
  logic       BtnClr;
  logic       J;
  logic       K;
  logic [1:0] Level;

  modport master (
    output BtnSet,
    output BtnClr,
    input  J,
    input  K,
    input  Level
  );

  modport slave (
    input  BtnSet,
    input  BtnClr,
    output J,
    output K,
    output Level
  );

endinterface

// File: rtl/jk_cmd_debouncer_btn_debounce.sv
// rtl/jk_cmd_debouncer_btn_debounce.sv - one button channel: synchroniser, debounce FSM, press pulse
//
// Purpose: accepts a level change only after DEBOUNCE_CYCLES consecutive identical
//          synchronised samples; emits a one-cycle pulse on each accepted press.
// Ports:   Ck     - clock
//          Reset  - synchronous active-high reset
//          btn    - raw asynchronous button
//          pulse  - registered one-cycle pulse on accepted press
//          level  - registered debounced level

module jk_cmd_debouncer_btn_debounce
  import jk_cmd_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16
) (
  input  logic Ck,
  input  logic Reset,
  input  logic btn,
  output logic pulse,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pulse_q;
  logic             pulse_nxt;
  logic             level_q;

  always_ff @(posedge Ck) begin
    if (Reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      state   <= IDLE;
      cnt     <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      s1      <= btn;
      s2      <= s1;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pulse_q <= pulse_nxt;
      // Level is registered from the next state so it rises together with the pulse.
      level_q <= (state_nxt == HIGH) || (state_nxt == CHECK_LOW);
    end
  end

  // The sample that leaves IDLE/HIGH counts as the first one, so the count
  // starts at 1 and acceptance happens when DEBOUNCE_CYCLES-1 is reached.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (s2) begin
          state_nxt = CHECK_HIGH;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      CHECK_HIGH: begin
        if (!s2) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s2) begin
          state_nxt = CHECK_LOW;
          cnt_nxt   = CNT_ONE;
        end
      end
      CHECK_LOW: begin
        if (s2) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign pulse = pulse_q;
  assign level = level_q;

endmodule

// File: rtl/jk_cmd_debouncer.sv
// rtl/jk_cmd_debouncer.sv - turns raw SET/CLR buttons into clean J/K pulses for the JK flip-flop
//
// Purpose: two independent debounce channels; SET drives J and Level[1], CLR drives K
//          and Level[0]. Simultaneous acceptance pulses J and K together (toggle command).
// Ports:   Ck    - clock
//          Reset - synchronous active-high reset
//          bus   - slave side of jk_cmd_debouncer_if (BtnSet, BtnClr, J, K, Level)

module jk_cmd_debouncer
  import jk_cmd_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16
) (
  input  logic               Ck,
  input  logic               Reset,
  jk_cmd_debouncer_if.slave  bus
);

  logic set_pulse;
  logic set_level;
  logic clr_pulse;
  logic clr_level;

  jk_cmd_debouncer_btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_set (
    .Ck    (Ck),
    .Reset (Reset),
    .btn   (bus.BtnSet),
    .pulse (set_pulse),
    .level (set_level)
  );

  jk_cmd_debouncer_btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_clr (
    .Ck    (Ck),
    .Reset (Reset),
    .btn   (bus.BtnClr),
    .pulse (clr_pulse),
    .level (clr_level)
  );

  assign bus.J     = set_pulse;
  assign bus.K     = clr_pulse;
  assign bus.Level = {set_level, clr_level};

endmodule

// File: tb/tb_jk_cmd_debouncer.sv
// tb/tb_jk_cmd_debouncer.sv - directed self-checking bench for jk_cmd_debouncer (DEBOUNCE_CYCLES=4)

module tb_jk_cmd_debouncer;

  logic Ck;
  logic Reset;
  int   checks;
  int   failures;
  int   jcount;

  jk_cmd_debouncer_if bus ();

  jk_cmd_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (16)
  ) dut (
    .Ck    (Ck),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Ck = 1'b0;
  always #5 Ck = ~Ck;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge Ck);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] observed, input logic [1:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    Reset      = 1'b1;
    bus.BtnSet = 1'b0;
    bus.BtnClr = 1'b0;
    #2;

    // Reset state
    do_reset();
    check("reset_J", {1'b0, bus.J}, 2'b00);
    check("reset_K", {1'b0, bus.K}, 2'b00);
    check("reset_Level", bus.Level, 2'b00);

    // Clean press: J only after edge 5, Level[1] from then on
    bus.BtnSet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("clean_J_e%0d", i), {1'b0, bus.J}, {1'b0, i == 5});
      check($sformatf("clean_K_e%0d", i), {1'b0, bus.K}, 2'b00);
      check($sformatf("clean_Lvl_e%0d", i), bus.Level, (i >= 5) ? 2'b10 : 2'b00);
    end
    // Release: no pulse, Level[1] falls after edge 5
    bus.BtnSet = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("rel_J_e%0d", i), {1'b0, bus.J}, 2'b00);
      check($sformatf("rel_Lvl_e%0d", i), bus.Level, (i < 5) ? 2'b10 : 2'b00);
    end

    // Bounce rejection on CLR
    for (int i = 0; i < 16; i++) begin
      bus.BtnClr = (i < 8) ? ((i % 2) == 0) : 1'b0;
      tick();
      check($sformatf("bounce_K_e%0d", i), {1'b0, bus.K}, 2'b00);
      check($sformatf("bounce_Lvl_e%0d", i), bus.Level, 2'b00);
    end

    // Short press of DEBOUNCE_CYCLES-1 samples is filtered
    for (int i = 0; i < 10; i++) begin
      bus.BtnSet = (i < 3);
      tick();
      check($sformatf("short_J_e%0d", i), {1'b0, bus.J}, 2'b00);
      check($sformatf("short_Lvl_e%0d", i), bus.Level, 2'b00);
    end

    // Bouncy press 1,0,1 then steady: pulse after edge 7
    for (int i = 0; i < 17; i++) begin
      bus.BtnSet = (i != 1);
      tick();
      check($sformatf("bouncy_J_e%0d", i), {1'b0, bus.J}, {1'b0, i == 7});
      check($sformatf("bouncy_Lvl_e%0d", i), bus.Level, (i >= 7) ? 2'b10 : 2'b00);
    end
    bus.BtnSet = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("bouncy_rel_J_e%0d", i), {1'b0, bus.J}, 2'b00);
      check($sformatf("bouncy_rel_Lvl_e%0d", i), bus.Level, (i < 5) ? 2'b10 : 2'b00);
    end

    // Simultaneous press: J and K in the same cycle, Level 11
    bus.BtnSet = 1'b1;
    bus.BtnClr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("sim_JK_e%0d", i), {bus.J, bus.K}, (i == 5) ? 2'b11 : 2'b00);
      check($sformatf("sim_Lvl_e%0d", i), bus.Level, (i >= 5) ? 2'b11 : 2'b00);
    end
    bus.BtnSet = 1'b0;
    bus.BtnClr = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("sim_release_Lvl", bus.Level, 2'b00);

    // Reset mid-debounce with SET held
    bus.BtnSet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rmid_pre_J_e%0d", i), {1'b0, bus.J}, 2'b00);
    end
    Reset = 1'b1;
    tick();
    check("rmid_in_reset_JK", {bus.J, bus.K}, 2'b00);
    check("rmid_in_reset_Lvl", bus.Level, 2'b00);
    Reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("rmid_post_J_e%0d", i), {1'b0, bus.J}, {1'b0, i == 5});
    end

    // Reset while HIGH clears Level immediately
    Reset = 1'b1;
    tick();
    check("rhigh_Lvl", bus.Level, 2'b00);
    check("rhigh_JK", {bus.J, bus.K}, 2'b00);
    Reset = 1'b0;
    bus.BtnSet = 1'b0;
    do_reset();

    // Held button for 100 cycles: exactly one J pulse
    jcount = 0;
    bus.BtnSet = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.J === 1'b1) jcount++;
    end
    check("held_J_count", jcount[1:0], 2'b01);
    check("held_J_total_small", {1'b0, jcount < 4}, 2'b01);
    check("held_Lvl", bus.Level, 2'b10);
    bus.BtnSet = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
